ysyx_22041752_divider: RTL

//   Multi-cycle RV64M divide unit: DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.

---
 rtl/ysyx_22041752_divider.sv | 97 +++++++++
 1 files changed

// File: rtl/ysyx_22041752_divider.sv
// ysyx_22041752_divider: multi-cycle RV64M restoring divider (DIV/DIVU/REM/REMU and W forms) with valid/ready handshakes
module ysyx_22041752_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            div_rem,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] div_result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] rem, quo, dvs, result;
  logic [CW-1:0] count;
  logic q_neg, r_neg, word, is_rem;
  logic [XLEN-1:0] a, b, mag1, mag2, special_res, rem_n, quo_n, fin_q, fin_r, fin;
  logic [XLEN:0] sh;
  logic s1, s2, zero, ovf, special, ge;
  function automatic logic [XLEN-1:0] sext(input logic w, input logic [XLEN-1:0] x);
    return w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
  endfunction
  // operand extension, magnitudes, special cases and one restoring step
  always_comb begin
    a = div_word ? {{HW{div_signed & div_src1[HW-1]}}, div_src1[HW-1:0]} : div_src1;
    b = div_word ? {{HW{div_signed & div_src2[HW-1]}}, div_src2[HW-1:0]} : div_src2;
    s1 = div_signed & a[XLEN-1];
    s2 = div_signed & b[XLEN-1];
    mag1 = s1 ? -a : a;
    mag2 = s2 ? -b : b;
    zero = b == '0;
    ovf = div_signed & (b == '1) &
          (a == (div_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}}));
    special = zero | ovf;
    special_res = sext(div_word, zero ? (div_rem ? a : '1) : (div_rem ? '0 : a));
    sh = {rem, quo[XLEN-1]};
    ge = sh >= {1'b0, dvs};
    rem_n = ge ? sh[XLEN-1:0] - dvs : sh[XLEN-1:0];
    quo_n = {quo[XLEN-2:0], ge};
    fin_q = q_neg ? -quo_n : quo_n;
    fin_r = r_neg ? -rem_n : rem_n;
    fin = sext(word, is_rem ? fin_r : fin_q);
  end
  // next-state: flush overrides everything except reset
  always_comb begin
    state_n = flush ? IDLE :
              (state == IDLE && div_valid) ? (special ? DONE : CALC) :
              (state == CALC && count == '0) ? DONE :
              (state == DONE && res_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // datapath: latch on accept, iterate in CALC, capture fixed-up result on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result <= '0;
      count <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      word <= 1'b0;
      is_rem <= 1'b0;
    end else if (!flush && state == IDLE && div_valid) begin
      rem <= '0;
      quo <= div_word ? {mag1[HW-1:0], {HW{1'b0}}} : mag1;
      dvs <= mag2;
      count <= div_word ? CW'(HW - 1) : CW'(XLEN - 1);
      q_neg <= s1 ^ s2;
      r_neg <= s1;
      word <= div_word;
      is_rem <= div_rem;
      if (special) result <= special_res;
    end else if (!flush && state == CALC) begin
      rem <= rem_n;
      quo <= quo_n;
      count <= count - 1'b1;
      if (count == '0) result <= fin;
    end
  end
  assign div_ready = state == IDLE;
  assign res_valid = state == DONE;
  assign div_result = result;
endmodule
